// File: rtl/capture_fifo.sv
// capture_fifo: first-word-fall-through buffer between the trigger-capture
// stage and a valid/ready consumer. Samples that arrive while the buffer is
// full and nothing drains are dropped. Each drop sets a sticky overflow flag
// and increments a saturating drop counter.
module capture_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [DW-1:0]            cap_data,
    input  logic                     cap_valid,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [CW-1:0]            drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    // Status flags come only from the registered level, so they cannot glitch with inputs.
    assign full      = (level == FULL_LEVEL);
    assign empty     = (level == '0);
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push during a pop.
    always_comb begin
        pop  = out_valid && out_ready && !clr;
        push = cap_valid && (!full || pop) && !clr;
        drop = cap_valid && full && !pop && !clr;
    end

    // Sample storage. It has no reset because entries past the pointers are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cap_data;
        end
    end

    // Pointers and occupancy. A flush has priority over any traffic in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + LEVEL_ONE;
            end else if (pop && !push) begin
                level <= level - LEVEL_ONE;
            end
        end
    end

    // Overflow bookkeeping. The counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_capture_fifo.sv
// tb_capture_fifo: randomized and directed stimulus for capture_fifo.
// The reference model is a plain queue with a drop counter. Popped data is
// checked by a separate monitor against a scoreboard queue.
module tb_capture_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int DROP_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          clr;
    logic [DW-1:0] cap_data;
    logic          cap_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [CW-1:0] drop_cnt;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] sb_q [$];
    int            model_drops;
    bit            model_over;

    int n_checks;
    int n_pass;

    capture_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .cap_data  (cap_data),
        .cap_valid (cap_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        int exp_head;
        exp_head = (model_q.size() > 0) ? int'(model_q[0]) : 0;
        checkValue({tag, ".level"},     int'(level),     model_q.size());
        checkValue({tag, ".full"},      int'(full),      int'(model_q.size() == DEPTH));
        checkValue({tag, ".empty"},     int'(empty),     int'(model_q.size() == 0));
        checkValue({tag, ".out_valid"}, int'(out_valid), int'(model_q.size() != 0));
        checkValue({tag, ".out_data"},  int'(out_data),  exp_head);
        checkValue({tag, ".overflow"},  int'(overflow),  int'(model_over));
        checkValue({tag, ".drop_cnt"},  int'(drop_cnt),  model_drops);
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then check the outputs after the edge.
    task automatic applyStimulus(input bit cv, input logic [DW-1:0] d, input bit rdy, input bit cl,
                                 input string tag);
        bit do_pop;
        bit has_room;
        cap_valid = cv;
        cap_data  = d;
        out_ready = rdy;
        clr       = cl;
        if (cl) begin
            model_q.delete();
            sb_q.delete();
            model_over  = 1'b0;
            model_drops = 0;
        end else begin
            has_room = (model_q.size() < DEPTH);
            do_pop   = (model_q.size() > 0) && rdy;
            if (do_pop) begin
                void'(model_q.pop_front());
            end
            if (cv && (has_room || do_pop)) begin
                model_q.push_back(d);
                sb_q.push_back(d);
            end else if (cv) begin
                model_over = 1'b1;
                if (model_drops < DROP_MAX) begin
                    model_drops++;
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic applyReset();
        #2;
        rst = 1'b1;
        model_q.delete();
        sb_q.delete();
        model_over  = 1'b0;
        model_drops = 0;
        #1;
        checkOutput("reset_async");
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release");
    endtask

    // Pop-side scoreboard. Every accepted transfer must match the oldest outstanding sample.
    always @(negedge clk) begin
        if (!rst && !clr && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL pop_unexpected: got %0h, expected no transfer", out_data);
            end else begin
                checkValue("pop_data", int'(out_data), int'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        model_drops = 0;
        model_over  = 1'b0;
        rst         = 1'b1;
        clr         = 1'b0;
        cap_valid   = 1'b0;
        cap_data    = '0;
        out_ready   = 1'b0;
        #1;
        checkOutput("reset_initial");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] ordering");
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, "ord_push");
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, "ord_push");
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, "ord_push");
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "ord_drain");

        $display("[TB] fill and drop");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        end
        repeat (9) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "fill_drain");

        $display("[TB] full with simultaneous push and pop");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "refill");
        end
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, "full_pushpop");
        repeat (9) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "full_drain");

        $display("[TB] clear priority");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "clr_fill");
        end
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, "clr");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "clr_after");

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, "rst_fill");
        end
        cap_valid = 1'b0;
        out_ready = 1'b0;
        applyReset();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 4,
                          $urandom_range(0, 59) == 0, "random");
        end

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 270; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, "saturate");
        end
        checkValue("drop_cnt_saturated", int'(drop_cnt), DROP_MAX);
        repeat (DEPTH + 1) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "final_drain");
        checkValue("scoreboard_leftover", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
